cc1200_reg_ctrl: RTL and testbench

//  Register-access sequencer that sits directly upstream of the CC1200 SPI byte engine.

---
 rtl/cc1200_pkg.sv | 28 ++
 rtl/cc1200_reg_ctrl_if.sv | 50 +++++
 rtl/cc1200_wr_prefetch.sv | 43 ++++
 rtl/cc1200_reg_ctrl.sv | 144 ++++++++++++++
 tb/tb_cc1200_reg_ctrl.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cc1200_pkg.sv
// Shared constants for the CC1200 register-access sequencer: header layout,
// address-space markers and FSM state encoding.
package cc1200_pkg;

  localparam int unsigned HDR_RW    = 7;
  localparam int unsigned HDR_BURST = 6;

  localparam logic [7:0] CC_EXT_ADDR = 8'h2F;
  localparam logic [7:0] STROBE_LO   = 8'h30;
  localparam logic [7:0] STROBE_HI   = 8'h3D;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StHdr  = 3'd1;
  localparam logic [2:0] StExt  = 3'd2;
  localparam logic [2:0] StData = 3'd3;
  localparam logic [2:0] StWait = 3'd4;
  localparam logic [2:0] StDone = 3'd5;

  function automatic logic [7:0] make_header(input logic rw, input logic burst,
                                             input logic [5:0] a);
    logic [7:0] h;
    h            = {2'b00, a};
    h[HDR_RW]    = rw;
    h[HDR_BURST] = burst;
    return h;
  endfunction

endpackage

// File: rtl/cc1200_reg_ctrl_if.sv
// Host command/data and SPI byte-engine signals of cc1200_reg_ctrl.
// CC1200_STROBE_EN adds the cmd_strobe request bit.
interface cc1200_reg_ctrl_if #(
  parameter int unsigned LEN_W = 6
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_read;
  logic             cmd_ext;
  logic [7:0]       cmd_addr;
  logic [LEN_W-1:0] cmd_len;
`ifdef CC1200_STROBE_EN
  logic             cmd_strobe;
`endif
  logic [7:0]       wr_data;
  logic             wr_valid;
  logic             wr_ready;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic [7:0]       status_byte;
  logic             done;
  logic             err_underrun;
  logic             spi_start;
  logic             spi_stop;
  logic [7:0]       spi_data_out;
  logic [7:0]       spi_data_in;
  logic             spi_load_nxt;
  logic             spi_busy;

  modport master (
`ifdef CC1200_STROBE_EN
    output cmd_strobe,
`endif
    output cmd_valid, cmd_read, cmd_ext, cmd_addr, cmd_len, wr_data, wr_valid,
    output spi_data_in, spi_load_nxt, spi_busy,
    input  cmd_ready, wr_ready, rd_data, rd_valid, status_byte, done, err_underrun,
    input  spi_start, spi_stop, spi_data_out
  );

  modport slave (
`ifdef CC1200_STROBE_EN
    input  cmd_strobe,
`endif
    input  cmd_valid, cmd_read, cmd_ext, cmd_addr, cmd_len, wr_data, wr_valid,
    input  spi_data_in, spi_load_nxt, spi_busy,
    output cmd_ready, wr_ready, rd_data, rd_valid, status_byte, done, err_underrun,
    output spi_start, spi_stop, spi_data_out
  );

endinterface

// File: rtl/cc1200_wr_prefetch.sv
// One-entry write-data holding register; an empty drain sends 0x00 and raises
// a sticky underrun flag until cleared.
module cc1200_wr_prefetch (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       drain,
  input  logic       clr_err,
  output logic [7:0] data,
  output logic       underrun
);
  logic       full_q;
  logic [7:0] data_q;
  logic       err_q;

  assign wr_ready = ~full_q;
  assign data     = full_q ? data_q : 8'h00;
  assign underrun = err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      full_q <= 1'b0;
      data_q <= 8'h00;
      err_q  <= 1'b0;
    end else begin
      // Loading is only possible while empty, so drain and load never collide.
      if (drain && full_q) begin
        full_q <= 1'b0;
      end else if (wr_valid && !full_q) begin
        full_q <= 1'b1;
        data_q <= wr_data;
      end
      if (clr_err) begin
        err_q <= 1'b0;
      end else if (drain && !full_q) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cc1200_reg_ctrl.sv
// CC1200 register-access sequencer: turns one command into the header/ext/data
// byte stream for the SPI byte engine. CC1200_STROBE_EN enables strobe commands.
module cc1200_reg_ctrl
  import cc1200_pkg::*;
#(
  parameter int unsigned LEN_W    = 6,
  parameter logic [7:0]  DUMMY    = 8'h00,
  parameter logic [7:0]  EXT_ADDR = CC_EXT_ADDR
) (
  input logic              clk,
  input logic              rstn,
  cc1200_reg_ctrl_if.slave bus
);
  localparam int unsigned CNT_W = LEN_W + 2;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, total_q, total_new, cap_idx_q;
  logic             read_q, ext_q, ld_q, rd_valid_q;
  logic [7:0]       addr_q, status_q, rd_data_q, header, pf_data, data_out;
  logic [LEN_W-1:0] len_eff;
  logic             accept, active, last_byte, next_is_data, ship_wr, strobe, pf_ready;
  logic             underrun;

`ifdef CC1200_STROBE_EN
  assign strobe = bus.cmd_strobe;
`else
  assign strobe = 1'b0;
`endif

  assign accept  = (state_q == StIdle) && bus.cmd_valid;
  assign active  = (state_q == StHdr) || (state_q == StExt) || (state_q == StData);
  assign len_eff = (bus.cmd_len == '0) ? LEN_W'(1) : bus.cmd_len;

  always_comb begin
    if (strobe) begin
      header    = make_header(1'b0, 1'b0, bus.cmd_addr[5:0]);
      total_new = CNT_W'(1);
    end else begin
      header    = make_header(bus.cmd_read, bus.cmd_len > LEN_W'(1),
                              bus.cmd_ext ? EXT_ADDR[5:0] : bus.cmd_addr[5:0]);
      total_new = CNT_W'(1) + CNT_W'(bus.cmd_ext) + CNT_W'(len_eff);
    end
  end

  // cnt_q counts completed bytes, so byte cnt_q+1 is on the wire.
  assign last_byte    = (cnt_q + CNT_W'(1)) == total_q;
  assign next_is_data = cnt_q >= CNT_W'(ext_q);
  assign ship_wr      = active && bus.spi_load_nxt && !last_byte && next_is_data && !read_q;

  always_comb begin
    data_out = 8'h00;
    if (state_q == StIdle) begin
      if (bus.cmd_valid) data_out = header;
    end else if (active) begin
      if (!next_is_data)  data_out = addr_q;
      else if (read_q)    data_out = DUMMY;
      else                data_out = pf_data;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StHdr;
          cnt_d   = '0;
        end
      end
      StHdr, StExt, StData: begin
        if (bus.spi_load_nxt) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (last_byte)                      state_d = StWait;
          else if (state_q == StHdr && ext_q) state_d = StExt;
          else                                state_d = StData;
        end
      end
      StWait:  if (!bus.spi_busy) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      total_q    <= '0;
      cap_idx_q  <= '0;
      read_q     <= 1'b0;
      ext_q      <= 1'b0;
      addr_q     <= 8'h00;
      ld_q       <= 1'b0;
      status_q   <= 8'h00;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        read_q  <= bus.cmd_read & ~strobe;
        ext_q   <= bus.cmd_ext & ~strobe;
        addr_q  <= bus.cmd_addr;
        total_q <= total_new;
      end
      // MISO byte is valid the cycle after its Load_Next.
      ld_q <= active && bus.spi_load_nxt;
      if (active && bus.spi_load_nxt) cap_idx_q <= cnt_q;
      rd_valid_q <= 1'b0;
      if (ld_q) begin
        if (cap_idx_q == '0) status_q <= bus.spi_data_in;
        if (read_q && (cap_idx_q >= CNT_W'(1) + CNT_W'(ext_q))) begin
          rd_data_q  <= bus.spi_data_in;
          rd_valid_q <= 1'b1;
        end
      end
    end
  end

  cc1200_wr_prefetch u_prefetch (
    .clk      (clk),
    .rstn     (rstn),
    .wr_data  (bus.wr_data),
    .wr_valid (bus.wr_valid),
    .wr_ready (pf_ready),
    .drain    (ship_wr),
    .clr_err  (accept),
    .data     (pf_data),
    .underrun (underrun)
  );

  assign bus.cmd_ready    = (state_q == StIdle);
  assign bus.wr_ready     = pf_ready;
  assign bus.rd_data      = rd_data_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.status_byte  = status_q;
  assign bus.done         = (state_q == StDone);
  assign bus.err_underrun = underrun;
  assign bus.spi_start    = accept;
  assign bus.spi_stop     = active && last_byte;
  assign bus.spi_data_out = data_out;

endmodule

// File: tb/tb_cc1200_reg_ctrl.sv
// Table-driven bench for cc1200_reg_ctrl with a behavioural SPI byte engine,
// a paced write-data source and a mid-transfer reset sequence.
module tb_cc1200_reg_ctrl;

  typedef struct {
    logic            strb;
    logic            rd;
    logic            ext;
    logic [7:0]      addr;
    logic [5:0]      len;
    int              nwr;
    logic [3:0][7:0] wr;
    logic [3:0][7:0] miso;
    int              n;
    logic [3:0][7:0] bytes;
    logic [7:0]      status;
    int              rd_cnt;
    logic [7:0]      rd0;
    logic [7:0]      rd_last;
    logic            underrun;
  } vec_t;

  localparam int BYTE_CYC = 3;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  cc1200_reg_ctrl_if #(.LEN_W(6)) bus ();

  cc1200_reg_ctrl #(.LEN_W(6)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int         n_pass = 0;
  int         n_total = 0;
  logic [7:0] miso [8];
  logic [7:0] tx_q [$];
  logic       stop_q [$];
  logic [7:0] wq [$];
  logic [7:0] rd_log [$];
  int         done_tot = 0;
  int         cyc = 0;
  int         fall_cyc = -1;
  int         done_cyc = -1;
  logic       err_after_acc;
  vec_t       vecs [$];

  function automatic logic [3:0][7:0] b4(input logic [7:0] a, b, c, d);
    logic [3:0][7:0] r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Behavioural byte engine: BYTE_CYC shift cycles, then one Load_Next cycle per byte.
  initial begin : engine
    int st, cnt, k;
    logic n_ld, n_busy;
    logic [7:0] n_din;
    st = 0; cnt = 0; k = 0;
    bus.spi_load_nxt = 1'b0;
    bus.spi_busy     = 1'b0;
    bus.spi_data_in  = 8'h00;
    forever begin
      @(negedge clk);
      n_ld = 1'b0; n_busy = bus.spi_busy; n_din = bus.spi_data_in;
      if (!rstn) begin
        st = 0; n_busy = 1'b0; n_din = 8'h00;
      end else begin
        case (st)
          0: if (bus.spi_start) begin
               tx_q.delete(); stop_q.delete();
               tx_q.push_back(bus.spi_data_out);
               k = 0; cnt = BYTE_CYC; n_busy = 1'b1; st = 1;
             end
          1: begin
               cnt--;
               if (cnt == 0) begin n_ld = 1'b1; st = 2; end
             end
          2: begin
               stop_q.push_back(bus.spi_stop);
               n_din = (k < 8) ? miso[k] : 8'h00;
               k++;
               if (bus.spi_stop) begin
                 cnt = 2; st = 3;
               end else begin
                 tx_q.push_back(bus.spi_data_out);
                 cnt = BYTE_CYC; st = 1;
               end
             end
          default: begin
               cnt--;
               if (cnt == 0) begin n_busy = 1'b0; st = 0; end
             end
        endcase
      end
      @(posedge clk); #1;
      bus.spi_load_nxt = n_ld;
      bus.spi_busy     = n_busy;
      bus.spi_data_in  = n_din;
    end
  end

  initial begin : writer
    bus.wr_valid = 1'b0;
    bus.wr_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.wr_valid && bus.wr_ready) void'(wq.pop_front());
      @(posedge clk); #1;
      if (wq.size() > 0) begin
        bus.wr_valid = 1'b1;
        bus.wr_data  = wq[0];
      end else begin
        bus.wr_valid = 1'b0;
      end
    end
  end

  initial begin : monitor
    logic prev_busy;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.rd_valid) rd_log.push_back(bus.rd_data);
      if (prev_busy && !bus.spi_busy) fall_cyc = cyc;
      if (bus.done) begin done_tot++; done_cyc = cyc; end
      prev_busy = bus.spi_busy;
    end
  end

  task automatic issue_cmd(input logic rd, input logic ext, input logic [7:0] addr,
                           input logic [5:0] len);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_read  = rd;
    bus.cmd_ext   = ext;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    err_after_acc = bus.err_underrun;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.done) begin ok = 1'b1; break; end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int   rd_base, done_base, nrd;
    bit   ok;
    logic [7:0] mask;
    for (int i = 0; i < v.nwr; i++) wq.push_back(v.wr[i]);
    for (int i = 0; i < 8; i++) miso[i] = (i < 4) ? v.miso[i] : 8'h00;
    repeat (4) @(posedge clk);
    rd_base = rd_log.size();
    done_base = done_tot;
`ifdef CC1200_STROBE_EN
    bus.cmd_strobe = v.strb;
`endif
    issue_cmd(v.rd, v.ext, v.addr, v.len);
`ifdef CC1200_STROBE_EN
    bus.cmd_strobe = 1'b0;
`endif
    check({tag, " underrun cleared on accept"}, err_after_acc, 0);
    wait_done(ok);
    check({tag, " done reached"}, ok, 1);
    check({tag, " byte count"}, tx_q.size(), v.n);
    for (int k = 0; k < v.n; k++)
      check($sformatf("%s byte%0d", tag, k), (k < tx_q.size()) ? tx_q[k] : 32'hFFFF, v.bytes[k]);
    mask = 8'h00;
    foreach (stop_q[i]) if (i < 8) mask[i] = stop_q[i];
    check({tag, " stop only at last load"}, mask, 8'h01 << (v.n - 1));
    check({tag, " status_byte"}, bus.status_byte, v.status);
    nrd = rd_log.size() - rd_base;
    check({tag, " rd_valid count"}, nrd, v.rd_cnt);
    if (v.rd_cnt > 0 && nrd > 0) begin
      check({tag, " first rd_data"}, rd_log[rd_base], v.rd0);
      check({tag, " last rd_data"}, rd_log[rd_log.size() - 1], v.rd_last);
    end
    check({tag, " err_underrun"}, bus.err_underrun, v.underrun);
    check({tag, " done pulses"}, done_tot - done_base, 1);
    check({tag, " done one cycle after busy falls"}, done_cyc - fall_cyc, 1);
  endtask

  initial begin : main
    bit ok;
    rstn = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_read  = 1'b0;
    bus.cmd_ext   = 1'b0;
    bus.cmd_addr  = 8'h00;
    bus.cmd_len   = 6'd0;
`ifdef CC1200_STROBE_EN
    bus.cmd_strobe = 1'b0;
`endif
    for (int i = 0; i < 8; i++) miso[i] = 8'h00;

    vecs.push_back('{strb:1'b0, rd:1'b0, ext:1'b0, addr:8'h0A, len:6'd1, nwr:1,
      wr:b4(8'h5A, 8'h00, 8'h00, 8'h00), miso:b4(8'h12, 8'h34, 8'h00, 8'h00), n:2,
      bytes:b4(8'h0A, 8'h5A, 8'h00, 8'h00), status:8'h12, rd_cnt:0, rd0:8'h00,
      rd_last:8'h00, underrun:1'b0});
    vecs.push_back('{strb:1'b0, rd:1'b1, ext:1'b1, addr:8'h8F, len:6'd1, nwr:0,
      wr:b4(8'h00, 8'h00, 8'h00, 8'h00), miso:b4(8'h0F, 8'h00, 8'hC3, 8'h00), n:3,
      bytes:b4(8'hAF, 8'h8F, 8'h00, 8'h00), status:8'h0F, rd_cnt:1, rd0:8'hC3,
      rd_last:8'hC3, underrun:1'b0});
    vecs.push_back('{strb:1'b0, rd:1'b0, ext:1'b0, addr:8'h01, len:6'd3, nwr:3,
      wr:b4(8'h11, 8'h22, 8'h33, 8'h00), miso:b4(8'h5E, 8'h00, 8'h00, 8'h00), n:4,
      bytes:b4(8'h41, 8'h11, 8'h22, 8'h33), status:8'h5E, rd_cnt:0, rd0:8'h00,
      rd_last:8'h00, underrun:1'b0});
    vecs.push_back('{strb:1'b0, rd:1'b0, ext:1'b0, addr:8'h05, len:6'd2, nwr:1,
      wr:b4(8'h77, 8'h00, 8'h00, 8'h00), miso:b4(8'h33, 8'h00, 8'h00, 8'h00), n:3,
      bytes:b4(8'h45, 8'h77, 8'h00, 8'h00), status:8'h33, rd_cnt:0, rd0:8'h00,
      rd_last:8'h00, underrun:1'b1});
    vecs.push_back('{strb:1'b0, rd:1'b1, ext:1'b0, addr:8'h7B, len:6'd2, nwr:0,
      wr:b4(8'h00, 8'h00, 8'h00, 8'h00), miso:b4(8'hA5, 8'h11, 8'h22, 8'h00), n:3,
      bytes:b4(8'hFB, 8'h00, 8'h00, 8'h00), status:8'hA5, rd_cnt:2, rd0:8'h11,
      rd_last:8'h22, underrun:1'b0});
    vecs.push_back('{strb:1'b0, rd:1'b0, ext:1'b1, addr:8'h10, len:6'd0, nwr:1,
      wr:b4(8'h99, 8'h00, 8'h00, 8'h00), miso:b4(8'h44, 8'h00, 8'h00, 8'h00), n:3,
      bytes:b4(8'h2F, 8'h10, 8'h99, 8'h00), status:8'h44, rd_cnt:0, rd0:8'h00,
      rd_last:8'h00, underrun:1'b0});
`ifdef CC1200_STROBE_EN
    vecs.push_back('{strb:1'b1, rd:1'b0, ext:1'b1, addr:8'h3D, len:6'd5, nwr:0,
      wr:b4(8'h00, 8'h00, 8'h00, 8'h00), miso:b4(8'h7E, 8'h00, 8'h00, 8'h00), n:1,
      bytes:b4(8'h3D, 8'h00, 8'h00, 8'h00), status:8'h7E, rd_cnt:0, rd0:8'h00,
      rd_last:8'h00, underrun:1'b0});
`endif

    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("reset cmd_ready", bus.cmd_ready, 1);
    check("reset wr_ready", bus.wr_ready, 1);
    check("reset spi_start", bus.spi_start, 0);
    check("reset spi_stop", bus.spi_stop, 0);
    check("reset spi_data_out", bus.spi_data_out, 8'h00);
    check("reset rd_valid", bus.rd_valid, 0);
    check("reset rd_data", bus.rd_data, 8'h00);
    check("reset status_byte", bus.status_byte, 8'h00);
    check("reset done", bus.done, 0);
    check("reset err_underrun", bus.err_underrun, 0);

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset in the data phase of a read with a byte parked in the prefetch register.
    wq.push_back(8'hE7);
    for (int i = 0; i < 8; i++) miso[i] = 8'h66;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("prefetch full before reset", bus.wr_ready, 0);
    issue_cmd(1'b1, 1'b0, 8'h02, 6'd3);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_q.size() >= 3) begin ok = 1'b1; break; end
    end
    check("reached data phase", ok, 1);
    #2 rstn = 1'b0;
    #1;
    check("midreset cmd_ready", bus.cmd_ready, 1);
    check("midreset rd_valid", bus.rd_valid, 0);
    check("midreset spi_start", bus.spi_start, 0);
    check("midreset spi_stop", bus.spi_stop, 0);
    check("midreset prefetch cleared", bus.wr_ready, 1);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (6) @(posedge clk);
    run_vec(vecs[1], "post-reset ext read");
    run_vec(vecs[0], "post-reset write");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
